// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared encodings and helpers for the CSR access unit
//
// Purpose: Zicsr funct3 encodings, implemented CSR addresses, sequencer
//          state enum and the implemented-address lookup.
// Ports:   none (package).
package csr_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [11:0] CSR_FFLAGS   = 12'h001;
  localparam logic [11:0] CSR_FRM      = 12'h002;
  localparam logic [11:0] CSR_FCSR     = 12'h003;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_e;

  function automatic logic is_implemented(input logic [11:0] addr);
    return addr inside {CSR_FFLAGS, CSR_FRM, CSR_FCSR, CSR_MSTATUS,
                        CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH};
  endfunction

endpackage

// File: rtl/csr_alu.sv
// rtl/csr_alu.sv - combinational Zicsr source select, new value, write enable, legality
//
// Purpose: given the latched instruction fields and the old CSR value,
//          produce the value to write, whether a write is wanted and
//          whether the instruction is illegal.
// Ports:
//   funct3_i     Zicsr funct3
//   csr_i        CSR address
//   rs1_val_i    rs1 register value (register forms)
//   rs1_idx_i    rs1 index / zimm (immediate forms)
//   old_val_i    current CSR contents
//   new_val_o    value to write
//   wen_o        write wanted (before legality gating)
//   illegal_o    illegal-instruction flag
module csr_alu
  import csr_pkg::*;
#(
  parameter bit CHECK_RO = 1'b1
) (
  input  logic [2:0]  funct3_i,
  input  logic [11:0] csr_i,
  input  logic [31:0] rs1_val_i,
  input  logic [4:0]  rs1_idx_i,
  input  logic [31:0] old_val_i,
  output logic [31:0] new_val_o,
  output logic        wen_o,
  output logic        illegal_o
);

  logic [31:0] src;
  logic        is_rw;
  logic        bad_f3;
  logic        ro_addr;

  always_comb begin
    src       = funct3_i[2] ? {27'b0, rs1_idx_i} : rs1_val_i;
    is_rw     = (funct3_i[1:0] == 2'b01);
    bad_f3    = (funct3_i[1:0] == 2'b00);
    ro_addr   = (csr_i[11:10] == 2'b11);
    new_val_o = src;
    case (funct3_i[1:0])
      2'b10:   new_val_o = old_val_i | src;
      2'b11:   new_val_o = old_val_i & ~src;
      default: new_val_o = src;
    endcase
    // Set/clear with x0 (or zimm 0) must not write, so a plain read of a
    // read-only counter stays legal.
    wen_o     = is_rw || (rs1_idx_i != 5'd0);
    illegal_o = bad_f3 || !is_implemented(csr_i) || (CHECK_RO && wen_o && ro_addr);
  end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - sequencer executing one Zicsr instruction against the CSR file
//
// Purpose: accept a decoded CSR instruction, read the old value, issue the
//          write, return the old value for rd and retire via instret step.
// Ports:
//   clk_i, reset_i               clock, asynchronous active-low reset
//   req_valid_i / req_ready_o    request handshake
//   req_funct3_i, req_csr_i      instruction funct3 and CSR address
//   req_rs1_val_i, req_rs1_idx_i rs1 value and rs1 index / zimm
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_rd_val_o, rsp_illegal_o  old CSR value and illegal flag
//   csrRAddr_o, csrRData_i       CSR file read port
//   csrWAddr_o, csrWData_o       CSR file write port
//   csrInstStep_o                one-cycle instret increment
module csr_access_unit
  import csr_pkg::*;
#(
  parameter logic [11:0] IDLE_ADDR = 12'h000,
  parameter bit          CHECK_RO  = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_funct3_i,
  input  logic [11:0] req_csr_i,
  input  logic [31:0] req_rs1_val_i,
  input  logic [4:0]  req_rs1_idx_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rd_val_o,
  output logic        rsp_illegal_o,
  output logic [11:0] csrRAddr_o,
  input  logic [31:0] csrRData_i,
  output logic [11:0] csrWAddr_o,
  output logic [31:0] csrWData_o,
  output logic        csrInstStep_o
);

  csr_state_e  state_q;
  logic        req_ready_q;
  logic [2:0]  funct3_q;
  logic [11:0] csr_q;
  logic [31:0] rs1_val_q;
  logic [4:0]  rs1_idx_q;
  logic        rsp_valid_q;
  logic [31:0] rd_val_q;
  logic        illegal_q;
  logic [11:0] raddr_q;
  logic [11:0] waddr_q;
  logic [31:0] wdata_q;

  logic [31:0] alu_new_val;
  logic        alu_wen;
  logic        alu_illegal;

  csr_alu #(
    .CHECK_RO (CHECK_RO)
  ) u_alu (
    .funct3_i  (funct3_q),
    .csr_i     (csr_q),
    .rs1_val_i (rs1_val_q),
    .rs1_idx_i (rs1_idx_q),
    .old_val_i (csrRData_i),
    .new_val_o (alu_new_val),
    .wen_o     (alu_wen),
    .illegal_o (alu_illegal)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      funct3_q    <= 3'b000;
      csr_q       <= IDLE_ADDR;
      rs1_val_q   <= 32'h0;
      rs1_idx_q   <= 5'd0;
      rsp_valid_q <= 1'b0;
      rd_val_q    <= 32'h0;
      illegal_q   <= 1'b0;
      raddr_q     <= IDLE_ADDR;
      waddr_q     <= IDLE_ADDR;
      wdata_q     <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Ready is registered so it stays low through reset and rises on
          // the first edge after release.
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            funct3_q    <= req_funct3_i;
            csr_q       <= req_csr_i;
            rs1_val_q   <= req_rs1_val_i;
            rs1_idx_q   <= req_rs1_idx_i;
            raddr_q     <= req_csr_i;
            req_ready_q <= 1'b0;
            state_q     <= ST_READ;
          end
        end
        ST_READ: begin
          // The old value is captured here, one cycle before the write, so
          // rd always sees the pre-write contents.
          raddr_q   <= IDLE_ADDR;
          rd_val_q  <= alu_illegal ? 32'h0 : csrRData_i;
          illegal_q <= alu_illegal;
          if (alu_wen && !alu_illegal) begin
            waddr_q <= csr_q;
            wdata_q <= alu_new_val;
          end
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          waddr_q     <= IDLE_ADDR;
          wdata_q     <= 32'h0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rd_val_q    <= 32'h0;
            illegal_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rd_val_o  = rd_val_q;
  assign rsp_illegal_o = illegal_q;
  assign csrRAddr_o    = raddr_q;
  assign csrWAddr_o    = waddr_q;
  assign csrWData_o    = wdata_q;
  // Retire exactly in the handshake cycle; the file increments at its end.
  assign csrInstStep_o = rsp_valid_q && rsp_ready_i && !illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - self-checking bench for csr_access_unit
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'b000;
  logic [11:0] req_csr = 12'h000;
  logic [31:0] req_rs1_val = 32'h0;
  logic [4:0]  req_rs1_idx = 5'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rd_val;
  logic        rsp_illegal;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        step;

  int checks = 0;
  int failures = 0;

  // Behavioural CSR file
  logic [31:0] f_fflags = 32'h0;
  logic [31:0] f_frm = 32'h0;
  logic [31:0] f_fcsr = 32'h0;
  logic [31:0] f_mstatus = 32'h0;
  logic [63:0] cycle_cnt = 64'h0;
  logic [63:0] instret_cnt = 64'h0;
  int write_count = 0;
  int step_count = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  csr_access_unit dut (
    .clk_i         (clk),
    .reset_i       (reset_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_funct3_i  (req_funct3),
    .req_csr_i     (req_csr),
    .req_rs1_val_i (req_rs1_val),
    .req_rs1_idx_i (req_rs1_idx),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rd_val_o  (rsp_rd_val),
    .rsp_illegal_o (rsp_illegal),
    .csrRAddr_o    (raddr),
    .csrRData_i    (rdata),
    .csrWAddr_o    (waddr),
    .csrWData_o    (wdata),
    .csrInstStep_o (step)
  );

  function automatic logic [31:0] file_val(input logic [11:0] a);
    case (a)
      12'h001: return f_fflags;
      12'h002: return f_frm;
      12'h003: return f_fcsr;
      12'h300: return f_mstatus;
      12'hC00: return cycle_cnt[31:0];
      12'hC02: return instret_cnt[31:0];
      12'hC80: return cycle_cnt[63:32];
      12'hC82: return instret_cnt[63:32];
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    rdata = 32'h0;
    case (raddr)
      12'h001: rdata = f_fflags;
      12'h002: rdata = f_frm;
      12'h003: rdata = f_fcsr;
      12'h300: rdata = f_mstatus;
      12'hC00: rdata = cycle_cnt[31:0];
      12'hC02: rdata = instret_cnt[31:0];
      12'hC80: rdata = cycle_cnt[63:32];
      12'hC82: rdata = instret_cnt[63:32];
      default: rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 64'd1;
    if (step) begin
      instret_cnt <= instret_cnt + 64'd1;
      step_count  <= step_count + 1;
    end
    if (waddr != 12'h000) begin
      write_count <= write_count + 1;
      case (waddr)
        12'h001: f_fflags  <= wdata;
        12'h002: f_frm     <= wdata;
        12'h003: f_fcsr    <= wdata;
        12'h300: f_mstatus <= wdata;
        default: ;
      endcase
    end
  end

  // Reference: Zicsr semantics stated directly from the instruction rules.
  function automatic void ref_op(input logic [2:0] f3, input logic [11:0] a,
                                 input logic [31:0] v, input logic [4:0] idx,
                                 input logic [31:0] old, output logic ill,
                                 output logic [31:0] rd, output logic wr,
                                 output logic [31:0] nv);
    logic [31:0] operand;
    logic        bad_op;
    logic        known;
    operand = (f3 >= 3'd5) ? {27'b0, idx} : v;
    bad_op  = 1'b0;
    wr      = 1'b0;
    nv      = old;
    case (f3)
      3'd1, 3'd5: begin nv = operand;        wr = 1'b1;        end
      3'd2, 3'd6: begin nv = old | operand;  wr = (idx != 0);  end
      3'd3, 3'd7: begin nv = old & ~operand; wr = (idx != 0);  end
      default:    bad_op = 1'b1;
    endcase
    known = a inside {12'h001, 12'h002, 12'h003, 12'h300,
                      12'hC00, 12'hC02, 12'hC80, 12'hC82};
    ill = bad_op || !known || (wr && a >= 12'hC00);
    rd  = ill ? 32'h0 : old;
    wr  = wr && !ill;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] v, input logic [4:0] idx, input int hold);
    logic        e_ill, e_wr;
    logic [31:0] e_rd, e_nv, old;
    int          w0, s0, n;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid   = 1'b1;
    req_funct3  = f3;
    req_csr     = a;
    req_rs1_val = v;
    req_rs1_idx = idx;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w0  = write_count;
    s0  = step_count;
    old = file_val(a);
    ref_op(f3, a, v, idx, old, e_ill, e_rd, e_wr, e_nv);
    n = 0;
    while (!rsp_valid && n < 8) begin
      chk("req_ready_busy", req_ready, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_latency", n, 2);
    chk("write_issued", write_count - w0, e_wr ? 1 : 0);
    chk("rsp_rd_val", rsp_rd_val, e_rd);
    chk("rsp_illegal", rsp_illegal, e_ill);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_rd", rsp_rd_val, e_rd);
      chk("hold_ready", req_ready, 1'b0);
      chk("hold_step", step, 1'b0);
      @(posedge clk); #1;
    end
    last_rd = rsp_rd_val;
    rsp_ready = 1'b1;
    #1;
    chk("step_in_handshake", step, !e_ill);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("step_count", step_count - s0, e_ill ? 0 : 1);
    chk("rsp_valid_drop", rsp_valid, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
    if (a inside {12'h001, 12'h002, 12'h003, 12'h300})
      chk("csr_after", file_val(a), e_wr ? e_nv : old);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [11:0] addrs [10];
    addrs = '{12'h001, 12'h002, 12'h003, 12'h300, 12'hC00,
              12'hC02, 12'hC80, 12'hC82, 12'h7C0, 12'h301};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rd_val", rsp_rd_val, 32'h0);
    chk("rst_illegal", rsp_illegal, 1'b0);
    chk("rst_step", step, 1'b0);
    chk("rst_raddr", raddr, 12'h000);
    chk("rst_waddr", waddr, 12'h000);
    chk("rst_wdata", wdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", req_ready, 1'b1);

    do_op(3'b001, 12'h300, 32'hDEADBEEF, 5'd1, 0);
    chk("dir_rw_rd", last_rd, 32'h0);
    chk("dir_rw_mstatus", f_mstatus, 32'hDEADBEEF);
    do_op(3'b001, 12'h300, 32'h0000000F, 5'd2, 0);
    chk("dir_rw2_rd", last_rd, 32'hDEADBEEF);
    do_op(3'b010, 12'h300, 32'h000000F0, 5'd5, 0);
    chk("dir_rs_rd", last_rd, 32'h0000000F);
    chk("dir_rs_mstatus", f_mstatus, 32'h000000FF);
    do_op(3'b111, 12'h300, 32'hFFFFFFFF, 5'd3, 0);
    chk("dir_rci_rd", last_rd, 32'h000000FF);
    chk("dir_rci_mstatus", f_mstatus, 32'h000000FC);

    do_op(3'b010, 12'hC00, 32'h12345678, 5'd0, 1);
    do_op(3'b001, 12'hC00, 32'h12345678, 5'd4, 0);
    do_op(3'b001, 12'h7C0, 32'hA5A5A5A5, 5'd6, 0);
    do_op(3'b100, 12'h300, 32'h0, 5'd7, 0);
    chk("dir_bad_f3_rd", last_rd, 32'h0);
    do_op(3'b010, 12'h300, 32'h0, 5'd0, 5);
    chk("dir_hold_rd", last_rd, 32'h000000FC);

    // Reset while the write is on the port: nothing may land.
    @(negedge clk);
    req_valid   = 1'b1;
    req_funct3  = 3'b001;
    req_csr     = 12'h300;
    req_rs1_val = 32'h12345678;
    req_rs1_idx = 5'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    w0 = write_count;
    chk("mid_write_addr", waddr, 12'h300);
    reset_n = 1'b0;
    #1;
    chk("arst_waddr", waddr, 12'h000);
    chk("arst_wdata", wdata, 32'h0);
    chk("arst_ready", req_ready, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_step", step, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_no_write", write_count - w0, 0);
    chk("arst_mstatus", f_mstatus, 32'h000000FC);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready_back", req_ready, 1'b1);
    do_op(3'b001, 12'h300, 32'h0BADF00D, 5'd1, 0);
    chk("post_reset_rd", last_rd, 32'h000000FC);
    chk("post_reset_mstatus", f_mstatus, 32'h0BADF00D);

    for (int k = 0; k < 60; k++) begin
      logic [2:0]  f3;
      logic [11:0] a;
      logic [31:0] v;
      logic [4:0]  idx;
      f3  = 3'($urandom_range(0, 7));
      a   = addrs[$urandom_range(0, 9)];
      v   = $urandom;
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op(f3, a, v, idx, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
